// File: rtl/stage2_pkg.sv
// Shared definitions for the stage-2 systolic controller and its argmax helper.
package stage2_pkg;

    localparam int N_OUT   = 10;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = 4;
    localparam int P_BUS_W = N_OUT * DATA_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        ARGMAX,
        DONE
    } state_e;

    // Product i lives in bits [i*DATA_W +: DATA_W] of the packed bus.
    function automatic logic signed [DATA_W-1:0] p_slice(
        input logic [P_BUS_W-1:0] bus,
        input int unsigned        i
    );
        return $signed(bus[i*DATA_W +: DATA_W]);
    endfunction

endpackage

// File: rtl/argmax_seq.sv
// Sequential signed argmax over N_OUT packed products: one load cycle, then one
// compare per cycle. Strict greater-than, so ties keep the lowest index.
module argmax_seq
    import stage2_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     step,
    input  logic [P_BUS_W-1:0]       p_bus,
    output logic                     active,
    output logic                     last,
    output logic signed [DATA_W-1:0] res_val,
    output logic [IDX_W-1:0]         res_idx
);

    logic signed [DATA_W-1:0] regs_q [N_OUT];
    logic signed [DATA_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        idx_d      = idx_q;
        if (load) begin
            best_d     = p_slice(p_bus, 0);
            best_idx_d = '0;
            idx_d      = IDX_W'(1);
        end else if (step && idx_q != '0) begin
            if (regs_q[idx_q] > best_q) begin
                best_d     = regs_q[idx_q];
                best_idx_d = idx_q;
            end
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // NOTE: the product register file has no reset; it is always loaded before
    // it is read, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N_OUT; i++) begin
                regs_q[i] <= p_slice(p_bus, i);
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            best_q     <= '0;
            best_idx_q <= '0;
            idx_q      <= '0;
        end else begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            idx_q      <= idx_d;
        end
    end

    assign active  = (idx_q != '0);
    assign last    = (idx_q == LAST_IDX);
    assign res_val = best_d;
    assign res_idx = best_idx_d;

endmodule

// File: rtl/systolic2_ctrl.sv
// Sequencer for the stage-2 systolic array: streams N_HIDDEN memory reads, gates
// the MAC start/stop, waits for the MAC pipeline, then runs the argmax.
module systolic2_ctrl
    import stage2_pkg::*;
#(
    parameter int N_HIDDEN = 32,
    parameter int ADDR_W   = 6,
    parameter int MAC_LAT  = 2,
    parameter int RD_LAT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   class_idx,
    output logic [DATA_W-1:0]  max_val,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mac_start,
    output logic               mac_stop,
    input  logic [P_BUS_W-1:0] p_bus
);

    localparam int CNT_W     = ADDR_W + 1;
    localparam int DRAIN_CYC = RD_LAT + MAC_LAT;
    localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

    localparam logic [CNT_W-1:0]   LAST_ELEM  = CNT_W'(N_HIDDEN - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYC - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         elem_q, elem_d;
    logic [DRAIN_W-1:0]       drain_q, drain_d;
    logic [RD_LAT-1:0]        rd_pipe_q, rd_pipe_d;
    logic [RD_LAT-1:0]        start_pipe_q, start_pipe_d;
    logic [IDX_W-1:0]         class_idx_q, class_idx_d;
    logic signed [DATA_W-1:0] max_val_q, max_val_d;

    logic                     am_load, am_step, am_active, am_last;
    logic signed [DATA_W-1:0] am_res_val;
    logic [IDX_W-1:0]         am_res_idx;

    argmax_seq u_argmax (
        .clk     (clk),
        .reset   (reset),
        .load    (am_load),
        .step    (am_step),
        .p_bus   (p_bus),
        .active  (am_active),
        .last    (am_last),
        .res_val (am_res_val),
        .res_idx (am_res_idx)
    );

    // DRAIN covers the read-latency tail of the operand stream plus the MAC drain.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        drain_d     = drain_q;
        class_idx_d = class_idx_q;
        max_val_d   = max_val_q;
        am_load     = 1'b0;
        am_step     = 1'b0;

        case (state_q)
            IDLE: begin
                elem_d  = '0;
                drain_d = '0;
                if (go) begin
                    state_d = FEED;
                end
            end
            FEED: begin
                if (elem_q == LAST_ELEM) begin
                    elem_d  = '0;
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    elem_d = elem_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    drain_d = '0;
                    state_d = ARGMAX;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ARGMAX: begin
                am_load = !am_active;
                am_step = am_active;
                if (am_active && am_last) begin
                    class_idx_d = am_res_idx;
                    max_val_d   = am_res_val;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read strobe and first-element marker delayed to the operand cycles.
    always_comb begin
        rd_pipe_d       = rd_pipe_q;
        start_pipe_d    = start_pipe_q;
        rd_pipe_d[0]    = (state_q == FEED);
        start_pipe_d[0] = (state_q == FEED) && (elem_q == '0);
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe_d[i]    = rd_pipe_q[i-1];
            start_pipe_d[i] = start_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            elem_q       <= '0;
            drain_q      <= '0;
            rd_pipe_q    <= '0;
            start_pipe_q <= '0;
            class_idx_q  <= '0;
            max_val_q    <= '0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            drain_q      <= drain_d;
            rd_pipe_q    <= rd_pipe_d;
            start_pipe_q <= start_pipe_d;
            class_idx_q  <= class_idx_d;
            max_val_q    <= max_val_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign mem_rd_en = (state_q == FEED);
    assign mem_addr  = elem_q[ADDR_W-1:0];
    assign mac_start = start_pipe_q[RD_LAT-1];
    assign mac_stop  = !rd_pipe_q[RD_LAT-1];
    assign class_idx = class_idx_q;
    assign max_val   = max_val_q;

endmodule

// File: doc/systolic2_ctrl.md
Name: systolic2_ctrl

Overview:
Sequencer for the stage-2 systolic array of ten MAC units that share one ReLU operand and use per-column weights. On a go pulse it streams N_HIDDEN address reads from the shared ReLU/weight memories, drives the MACs' start/stop so that exactly elements 0..N_HIDDEN-1 accumulate, and waits for the MAC pipeline to drain. It then runs a sequential signed argmax over the ten products and reports the predicted digit. It sits between the top-level inference FSM and the systolic2 instance.

Parameters:
N_HIDDEN, 32, number of hidden-layer elements accumulated per job (>=1)
ADDR_W, 6, memory address width (2**ADDR_W >= N_HIDDEN)
MAC_LAT, 2, cycles from last mac_stop-low operand cycle to stable p outputs (>=1)
RD_LAT, 1, fixed read latency of the ReLU and weight memories (cycles)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
go  in  1  job request; sampled only in IDLE
busy  out  1  high from first FEED cycle through the done cycle inclusive
done  out  1  one-cycle pulse; class_idx/max_val valid in the same cycle
class_idx  out  4  argmax index 0..9, held until the next done
max_val  out  32  signed value of the winning product, held until the next done
mem_rd_en  out  1  read strobe to the ReLU buffer and weight ROM
mem_addr  out  ADDR_W  element index k
mac_start  out  1  to systolic2 start: high with element 0 at the MAC inputs
mac_stop  out  1  to systolic2 stop: freezes the accumulators
p_bus  in  320  p9..p0 packed, p0 in bits [31:0], signed 32-bit each

Behaviour:
- Reset values: busy=0, done=0, class_idx=0, max_val=0, mem_rd_en=0, mem_addr=0, mac_start=0, mac_stop=1. State is IDLE; all counters are 0.
- States: IDLE -> FEED -> DRAIN -> ARGMAX -> DONE -> IDLE.
- IDLE: mac_stop=1. go=1 at edge E0 moves to FEED. go in any other state is ignored; it is not queued.
- Timing is relative to the go edge; cycle c is the c-th cycle after E0.
- FEED, cycles 1..N_HIDDEN: mem_rd_en=1 and mem_addr=c-1. Exits after addr N_HIDDEN-1 is issued.
- Operand cycles are 1+RD_LAT .. N_HIDDEN+RD_LAT. mac_start=1 only in cycle 1+RD_LAT. mac_stop=0 across all operand cycles and 1 otherwise.
- DRAIN: MAC_LAT cycles, counted from the cycle after the last operand.
- ARGMAX entry cycle: latch p_bus into ten internal registers; best=p0, best_idx=0.
- ARGMAX steps: next 9 cycles compare entry i=1..9. Replace only if p_i > best (signed, strict), so ties keep the lowest index.
- DONE: a single cycle with done=1. class_idx and max_val update on the edge entering DONE. Return to IDLE; a go sampled in the DONE cycle is ignored.
- Total latency with defaults: done in cycle N_HIDDEN+RD_LAT+MAC_LAT+11 = 46.
- N_HIDDEN=1: mac_start and the single operand share cycle 1+RD_LAT; mac_stop rises in the next cycle.
- Counters: element counter wraps never; it is cleared in IDLE. Its width is ADDR_W+1 so that N_HIDDEN = 2**ADDR_W is legal.
- Reset mid-job, in any state: next cycle matches the reset values. Partial results are discarded; class_idx/max_val go to 0. No done pulse is produced.
- mac_stop=1 whenever busy=0, so the array stays frozen between jobs. The next mac_start reloads the accumulators.

Decomposition:
- Shared package (stage2_pkg): N_OUT=10, DATA_W=32, the state enum typedef (IDLE, FEED, DRAIN, ARGMAX, DONE), and p_bus slice helper constants.
- Sub-module argmax_seq: load/step/result interface, 10x32 signed register file, best/best_idx registers, 4-bit index counter. It is reusable for the stage-1 classifier check.
- The top holds the FSM, address/element counter, and RD_LAT/MAC_LAT delay shifters.

Test Plan:
- The bench instantiates systolic2 with behavioural ReLU/weight memories (RD_LAT=1), using defaults.
- All w=1, relu[k]=k+1, go once -> p_i=528 all; done in cycle 46; class_idx=0 (tie rule), max_val=528; mac_start high only in cycle 2; mac_stop low in cycles 2..33.
- w7=2, others 1, same relu -> class_idx=7, max_val=1056; busy high in cycles 1..46; mem_addr 0..31 in cycles 1..32.
- Weights -i-1 for column i, relu[k]=1 -> p_i=-32*(i+1); class_idx=0, max_val=-32 (signed compare, least negative wins).
- go pulsed in cycles 5 and 46 of a running job -> both ignored; a single done; a new go in cycle 47 starts a second job.
- reset in cycle 10 of FEED -> next cycle busy=0, mac_stop=1, mem_rd_en=0, class_idx=0; no done. A fresh job afterwards gives the correct result.
- N_HIDDEN=1, relu[0]=5, w3=3, others 1 -> mac_start and mac_stop=0 in cycle 2 only; class_idx=3, max_val=15; done in cycle 15.
